// File: rtl/ita_output_stage_pkg.sv
// ita_output_stage_pkg
// Shared constants and types for the ITA output stage (row FIFO + beat
// serializer sitting after activation). Integration-level defaults live
// here. ita_output_stage still takes them as overridable parameters so a
// narrower output port can be built without touching this package.
package ita_output_stage_pkg;

  localparam int RowLanes     = 16;        // lanes per requantized row
  localparam int LaneW        = 8;         // bits per lane
  localparam int OutLanes     = RowLanes;  // lanes per output beat
  localparam int OutFifoDepth = 8;         // buffered rows
  localparam int OutStallTh   = 2;         // rows still in flight upstream
  localparam int RowTagW      = 4;         // step encoding width

  typedef logic [OutLanes-1:0][LaneW-1:0]       out_beat_t;
  typedef logic [RowTagW-1:0]                   row_tag_t;
  typedef logic [$clog2(OutFifoDepth+1)-1:0]    out_usage_t;

  // Beats needed to send one row. out_lanes must divide lanes.
  function automatic int beat_count(input int lanes, input int out_lanes);
    return lanes / out_lanes;
  endfunction

endpackage

// File: rtl/ita_output_stage_if.sv
// ita_output_stage_if
// Output beat channel of the ITA output stage (valid/ready).
//   valid     : beat on data/tag is valid
//   ready     : sink accepts the beat this cycle
//   data      : beat payload, lowest lane in LSBs; '0 while valid is low
//   tag       : producing-step tag of the current row; '0 while valid is low
//   last_beat : current beat is the final beat of its row
// master = output stage side, slave = consumer side.
interface ita_output_stage_if
  import ita_output_stage_pkg::*;
#(
  parameter int DATA_W = OutLanes * LaneW,
  parameter int TAG_W  = RowTagW
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [TAG_W-1:0]  tag;
  logic              last_beat;

  modport master (output valid, data, tag, last_beat, input ready);
  modport slave  (input valid, data, tag, last_beat, output ready);

endinterface

// File: rtl/ita_output_stage_row_serializer.sv
// ita_row_serializer
// Splits the FIFO head row into N/OUT_LANES beats, lowest lanes first.
// Owns the beat counter and tells the FIFO when the head row is done.
//   clk        : clock
//   clr        : synchronous clear of the beat counter (reset or flush)
//   head_valid : FIFO holds at least one row
//   head_row   : head row, lane 0 in LSBs
//   head_tag   : head row tag
//   pop        : last beat of the head row transfers this cycle
//   out        : output beat channel (master side)
module ita_row_serializer
  import ita_output_stage_pkg::*;
#(
  parameter int N         = RowLanes,
  parameter int WI        = LaneW,
  parameter int OUT_LANES = OutLanes,
  parameter int TAG_W     = RowTagW
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 head_valid,
  input  logic [N*WI-1:0]      head_row,
  input  logic [TAG_W-1:0]     head_tag,
  output logic                 pop,
  ita_output_stage_if.master   out
);

  localparam int BEATS  = beat_count(N, OUT_LANES);
  localparam int BC_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BEAT_W = OUT_LANES * WI;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BEATS - 1);
  localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);

  logic [BC_W-1:0]              bc;
  logic [BEATS-1:0][BEAT_W-1:0] beats;
  logic                         at_last;

  // View the row as an array of beats; beat 0 holds the lowest lanes.
  assign beats   = head_row;
  // With a single beat per row BC_LAST is 0 and bc never leaves 0,
  // so last_beat simply follows valid.
  assign at_last = (bc == BC_LAST);

  // NOTE: every output gets a default before the conditional so no latch
  // is inferred when head_valid is low.
  always_comb begin
    out.valid     = head_valid;
    out.data      = '0;
    out.tag       = '0;
    out.last_beat = 1'b0;
    pop           = 1'b0;
    if (head_valid) begin
      out.data      = beats[bc];
      out.tag       = head_tag;
      out.last_beat = at_last;
      pop           = out.ready && at_last;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (clr) begin
      bc <= '0;
    end else if (head_valid && out.ready) begin
      bc <= at_last ? '0 : bc + BC_ONE;
    end
  end

endmodule

// File: rtl/ita_output_stage.sv
// ita_output_stage
// Output buffer and serializer placed after activation. Whole rows of N
// requantized lanes are pushed (no ready; upstream obeys stall_o), held in
// a DEPTH-row non-fall-through FIFO and streamed as N/OUT_LANES beats.
//   clk_i       : clock
//   rst_i       : synchronous active-high reset
//   flush_i     : synchronous clear of buffered rows and status
//   push_i      : row valid
//   data_i      : row data, lane 0 in LSBs
//   tag_i       : row tag
//   stall_o     : free rows <= STALL_TH, upstream must stop pushing
//   out         : output beat channel (master side)
//   usage_o     : rows stored
//   usage_max_o : high-water mark of usage since reset/flush
//   overflow_o  : sticky, a push was dropped while full
module ita_output_stage
  import ita_output_stage_pkg::*;
#(
  parameter int N         = RowLanes,
  parameter int WI        = LaneW,
  parameter int OUT_LANES = OutLanes,
  parameter int DEPTH     = OutFifoDepth,
  parameter int STALL_TH  = OutStallTh,
  parameter int TAG_W     = RowTagW
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [N*WI-1:0]              data_i,
  input  logic [TAG_W-1:0]             tag_i,
  output logic                         stall_o,
  ita_output_stage_if.master           out,
  output logic [$clog2(DEPTH+1)-1:0]   usage_o,
  output logic [$clog2(DEPTH+1)-1:0]   usage_max_o,
  output logic                         overflow_o
);

  localparam int UW    = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  // Usage level at which stall_o asserts; clamps to 0 for STALL_TH >= DEPTH.
  localparam int STALL_LVL = (STALL_TH >= DEPTH) ? 0 : DEPTH - STALL_TH;
  localparam logic [UW-1:0]    USE_FULL  = UW'(DEPTH);
  localparam logic [UW-1:0]    USE_STALL = UW'(STALL_LVL);
  localparam logic [UW-1:0]    USE_ONE   = UW'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [N*WI-1:0]  row_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [UW-1:0]    usage, usage_next, usage_max;
  logic             overflow;
  logic             clr, head_valid, pop, push_ok, push_drop;

  assign clr        = rst_i | flush_i;
  assign head_valid = (usage != '0);

  // A pop in the same cycle frees the head slot, so a push into a full
  // FIFO still lands; pointers are equal when full, and the write to the
  // head slot happens at the same edge that retires it.
  assign push_ok   = push_i && !clr && ((usage != USE_FULL) || pop);
  assign push_drop = push_i && (usage == USE_FULL) && !pop;

  always_comb begin
    usage_next = usage;
    case ({push_ok, pop})
      2'b10:   usage_next = usage + USE_ONE;
      2'b01:   usage_next = usage - USE_ONE;
      default: usage_next = usage;
    endcase
  end

  // Reset and flush share one path; flush also outranks a concurrent push
  // (which is discarded without flagging overflow).
  always_ff @(posedge clk_i) begin
    if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      usage     <= '0;
      usage_max <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      usage <= usage_next;
      if (usage_next > usage_max) usage_max <= usage_next;
      if (push_drop) overflow <= 1'b1;
    end
  end

  // NOTE: row storage is deliberately not reset; valid_o is derived from
  // usage, so stale contents are never observable and the array stays
  // plain flops without a reset tree.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      row_mem[wr_ptr] <= data_i;
      tag_mem[wr_ptr] <= tag_i;
    end
  end

  ita_row_serializer #(
    .N         (N),
    .WI        (WI),
    .OUT_LANES (OUT_LANES),
    .TAG_W     (TAG_W)
  ) u_serializer (
    .clk        (clk_i),
    .clr        (clr),
    .head_valid (head_valid),
    .head_row   (row_mem[rd_ptr]),
    .head_tag   (tag_mem[rd_ptr]),
    .pop        (pop),
    .out        (out)
  );

  assign stall_o     = (usage >= USE_STALL);
  assign usage_o     = usage;
  assign usage_max_o = usage_max;
  assign overflow_o  = overflow;

endmodule

// File: tb/tb_ita_output_stage.sv
// tb_ita_output_stage
// Directed bench for ita_output_stage with N=16, WI=8, OUT_LANES=4,
// DEPTH=8, STALL_TH=2, TAG_W=4. Inputs change 1 ns after the rising edge;
// outputs are compared in the same window, before the next edge.
module tb_ita_output_stage;

  localparam int N     = 16;
  localparam int WI    = 8;
  localparam int OL    = 4;
  localparam int DEPTH = 8;
  localparam int STH   = 2;
  localparam int TW    = 4;
  localparam int DW    = OL * WI;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          push = 1'b0;
  logic [N*WI-1:0] din = '0;
  logic [TW-1:0] tin = '0;
  logic          stall;
  logic [3:0]    usage;
  logic [3:0]    usage_max;
  logic          overflow;

  int vectors = 0;
  int miscompares = 0;

  ita_output_stage_if #(.DATA_W(DW), .TAG_W(TW)) out_if ();

  ita_output_stage #(
    .N(N), .WI(WI), .OUT_LANES(OL), .DEPTH(DEPTH), .STALL_TH(STH), .TAG_W(TW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .push_i      (push),
    .data_i      (din),
    .tag_i       (tin),
    .stall_o     (stall),
    .out         (out_if),
    .usage_o     (usage),
    .usage_max_o (usage_max),
    .overflow_o  (overflow)
  );

  always #5 clk = ~clk;

  // Row whose lane i holds base+i (mod 256).
  function automatic logic [N*WI-1:0] make_row(input logic [7:0] base);
    logic [N*WI-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*8 +: 8] = base + 8'(i);
    return r;
  endfunction

  // Beat k of the row built by make_row(base).
  function automatic logic [DW-1:0] exp_beat(input logic [7:0] base, input int k);
    logic [DW-1:0] b;
    b = '0;
    for (int i = 0; i < OL; i++) b[i*8 +: 8] = base + 8'(4*k + i);
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_if.ready = 1'b0;
    tick();
    rst = 1'b0;
    vectors++;
    if ({out_if.valid, out_if.last_beat, out_if.tag, out_if.data} !== 38'h0) begin
      miscompares++;
      $display("FAIL reset_bus: got %h want 0",
               {out_if.valid, out_if.last_beat, out_if.tag, out_if.data});
    end
    vectors++;
    if ({stall, usage, usage_max, overflow} !== 10'h0) begin
      miscompares++;
      $display("FAIL reset_status: got %h want 0", {stall, usage, usage_max, overflow});
    end
  endtask

  task automatic test_single_row();
    out_if.ready = 1'b1;
    din = make_row(8'h00);
    tin = 4'd3;
    push = 1'b1;
    vectors++;
    if (out_if.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_no_fallthrough: got valid %b want 0", out_if.valid);
    end
    tick();
    push = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if ({out_if.valid, out_if.last_beat, out_if.tag, out_if.data} !==
          {1'b1, (k == 3), 4'd3, exp_beat(8'h00, k)}) begin
        miscompares++;
        $display("FAIL single_beat%0d: got v%b l%b t%h d%h want v1 l%b t3 d%h", k,
                 out_if.valid, out_if.last_beat, out_if.tag, out_if.data,
                 (k == 3), exp_beat(8'h00, k));
      end
      tick();
    end
    vectors++;
    if ({usage, out_if.valid, out_if.data} !== 37'h0) begin
      miscompares++;
      $display("FAIL single_drained: got usage %0d valid %b data %h want 0 0 0",
               usage, out_if.valid, out_if.data);
    end
  endtask

  task automatic test_fill_overflow();
    out_if.ready = 1'b0;
    for (int r = 0; r < 8; r++) begin
      din = make_row(8'(r * 16));
      tin = 4'(r);
      push = 1'b1;
      vectors++;
      if ({usage, stall} !== {4'(r), (r >= 6)}) begin
        miscompares++;
        $display("FAIL fill_stall r%0d: got usage %0d stall %b want %0d %b",
                 r, usage, stall, r, (r >= 6));
      end
      tick();
    end
    din = make_row(8'h80);
    tin = 4'hF;
    vectors++;
    if ({usage, stall, overflow} !== {4'd8, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL fill_full: got usage %0d stall %b ovf %b want 8 1 0",
               usage, stall, overflow);
    end
    tick();
    push = 1'b0;
    vectors++;
    if ({usage, overflow} !== {4'd8, 1'b1}) begin
      miscompares++;
      $display("FAIL overflow_push: got usage %0d ovf %b want 8 1", usage, overflow);
    end
    out_if.ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if ({out_if.valid, out_if.last_beat, out_if.tag, out_if.data} !==
            {1'b1, (k == 3), 4'(r), exp_beat(8'(r * 16), k)}) begin
          miscompares++;
          $display("FAIL drain r%0d b%0d: got v%b l%b t%h d%h want v1 l%b t%h d%h", r, k,
                   out_if.valid, out_if.last_beat, out_if.tag, out_if.data,
                   (k == 3), 4'(r), exp_beat(8'(r * 16), k));
        end
        tick();
      end
    end
    vectors++;
    if ({usage, overflow, usage_max} !== {4'd0, 1'b1, 4'd8}) begin
      miscompares++;
      $display("FAIL drain_status: got usage %0d ovf %b max %0d want 0 1 8",
               usage, overflow, usage_max);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors++;
    if ({overflow, usage_max} !== 5'h0) begin
      miscompares++;
      $display("FAIL flush_clears_ovf: got ovf %b max %0d want 0 0", overflow, usage_max);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] base;
    logic [3:0] tg;
    out_if.ready = 1'b0;
    for (int r = 0; r < 8; r++) begin
      din = make_row(8'(r * 16 + 1));
      tin = 4'(r);
      push = 1'b1;
      tick();
    end
    push = 1'b0;
    out_if.ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    vectors++;
    if ({usage, out_if.last_beat, out_if.data} !== {4'd8, 1'b1, exp_beat(8'h01, 3)}) begin
      miscompares++;
      $display("FAIL full_last_beat: got usage %0d last %b d %h want 8 1 %h",
               usage, out_if.last_beat, out_if.data, exp_beat(8'h01, 3));
    end
    din = make_row(8'hA0);
    tin = 4'hA;
    push = 1'b1;
    tick();
    push = 1'b0;
    vectors++;
    if ({usage, overflow} !== {4'd8, 1'b0}) begin
      miscompares++;
      $display("FAIL full_push_pop: got usage %0d ovf %b want 8 0", usage, overflow);
    end
    for (int r = 1; r < 9; r++) begin
      base = (r < 8) ? 8'(r * 16 + 1) : 8'hA0;
      tg   = (r < 8) ? 4'(r) : 4'hA;
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if ({out_if.valid, out_if.last_beat, out_if.tag, out_if.data} !==
            {1'b1, (k == 3), tg, exp_beat(base, k)}) begin
          miscompares++;
          $display("FAIL full_drain r%0d b%0d: got t%h d%h want t%h d%h", r, k,
                   out_if.tag, out_if.data, tg, exp_beat(base, k));
        end
        tick();
      end
    end
    vectors++;
    if (usage !== 4'd0) begin
      miscompares++;
      $display("FAIL full_drained: got usage %0d want 0", usage);
    end
  endtask

  task automatic test_random_ready();
    int pushed = 0;
    int exp_row = 0;
    int exp_k = 0;
    int cycles = 0;
    logic hold = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [TW-1:0] prev_tag = '0;
    while (exp_row < 100 && cycles < 5000) begin
      out_if.ready = 1'($urandom_range(0, 1));
      push = (pushed < 100) && !stall;
      if (push) begin
        din = make_row(8'(pushed * 7));
        tin = 4'(pushed);
      end
      if (hold) begin
        vectors++;
        if ({out_if.valid, out_if.tag, out_if.data} !== {1'b1, prev_tag, prev_data}) begin
          miscompares++;
          $display("FAIL rand_hold c%0d: got v%b t%h d%h want v1 t%h d%h", cycles,
                   out_if.valid, out_if.tag, out_if.data, prev_tag, prev_data);
        end
      end
      if (out_if.valid) begin
        vectors++;
        if ({out_if.last_beat, out_if.tag, out_if.data} !==
            {(exp_k == 3), 4'(exp_row), exp_beat(8'(exp_row * 7), exp_k)}) begin
          miscompares++;
          $display("FAIL rand_beat r%0d b%0d: got l%b t%h d%h want l%b t%h d%h",
                   exp_row, exp_k, out_if.last_beat, out_if.tag, out_if.data,
                   (exp_k == 3), 4'(exp_row), exp_beat(8'(exp_row * 7), exp_k));
        end
      end else begin
        vectors++;
        if ({out_if.last_beat, out_if.tag, out_if.data} !== 37'h0) begin
          miscompares++;
          $display("FAIL rand_idle_zero c%0d: got l%b t%h d%h want 0", cycles,
                   out_if.last_beat, out_if.tag, out_if.data);
        end
      end
      hold = out_if.valid && !out_if.ready;
      prev_data = out_if.data;
      prev_tag = out_if.tag;
      if (out_if.valid && out_if.ready) begin
        exp_k++;
        if (exp_k == 4) begin
          exp_k = 0;
          exp_row++;
        end
      end
      if (push) pushed++;
      tick();
      cycles++;
    end
    push = 1'b0;
    vectors++;
    if ({exp_row, usage, overflow} !== {32'd100, 4'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL rand_complete: got rows %0d usage %0d ovf %b want 100 0 0",
               exp_row, usage, overflow);
    end
  endtask

  task automatic test_flush_mid_row();
    out_if.ready = 1'b1;
    din = make_row(8'h10);
    tin = 4'd5;
    push = 1'b1;
    tick();
    push = 1'b0;
    tick();
    tick();
    vectors++;
    if ({out_if.valid, out_if.last_beat, out_if.tag, out_if.data} !==
        {1'b1, 1'b0, 4'd5, exp_beat(8'h10, 2)}) begin
      miscompares++;
      $display("FAIL flush_pre_bc2: got v%b l%b t%h d%h want v1 l0 t5 d%h",
               out_if.valid, out_if.last_beat, out_if.tag, out_if.data, exp_beat(8'h10, 2));
    end
    flush = 1'b1;
    din = make_row(8'h50);
    tin = 4'd7;
    push = 1'b1;
    tick();
    flush = 1'b0;
    push = 1'b0;
    vectors++;
    if ({out_if.valid, usage, usage_max, overflow, out_if.data} !== 42'h0) begin
      miscompares++;
      $display("FAIL flush_state: got v%b usage %0d max %0d ovf %b d %h want all 0",
               out_if.valid, usage, usage_max, overflow, out_if.data);
    end
    din = make_row(8'h60);
    tin = 4'd6;
    push = 1'b1;
    tick();
    push = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if ({out_if.valid, out_if.last_beat, out_if.tag, out_if.data} !==
          {1'b1, (k == 3), 4'd6, exp_beat(8'h60, k)}) begin
        miscompares++;
        $display("FAIL flush_next_b%0d: got v%b l%b t%h d%h want v1 l%b t6 d%h", k,
                 out_if.valid, out_if.last_beat, out_if.tag, out_if.data,
                 (k == 3), exp_beat(8'h60, k));
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_stream();
    out_if.ready = 1'b0;
    for (int r = 0; r < 5; r++) begin
      din = make_row(8'(r * 3));
      tin = 4'(r);
      push = 1'b1;
      tick();
    end
    push = 1'b0;
    vectors++;
    if (usage !== 4'd5) begin
      miscompares++;
      $display("FAIL rst_prefill: got usage %0d want 5", usage);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({out_if.valid, out_if.last_beat, out_if.tag, out_if.data,
         stall, usage, usage_max, overflow} !== 48'h0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got v%b l%b t%h d%h s%b u%0d m%0d o%b want all 0",
               out_if.valid, out_if.last_beat, out_if.tag, out_if.data,
               stall, usage, usage_max, overflow);
    end
    for (int r = 0; r < 3; r++) begin
      din = make_row(8'hC0 + 8'(r * 16));
      tin = 4'(9 + r);
      push = 1'b1;
      tick();
    end
    push = 1'b0;
    vectors++;
    if ({usage, usage_max} !== {4'd3, 4'd3}) begin
      miscompares++;
      $display("FAIL rst_refill: got usage %0d max %0d want 3 3", usage, usage_max);
    end
    out_if.ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if ({out_if.valid, out_if.tag, out_if.data} !==
            {1'b1, 4'(9 + r), exp_beat(8'hC0 + 8'(r * 16), k)}) begin
          miscompares++;
          $display("FAIL rst_drain r%0d b%0d: got v%b t%h d%h want v1 t%h d%h", r, k,
                   out_if.valid, out_if.tag, out_if.data, 4'(9 + r),
                   exp_beat(8'hC0 + 8'(r * 16), k));
        end
        tick();
      end
    end
    vectors++;
    if ({usage, usage_max} !== {4'd0, 4'd3}) begin
      miscompares++;
      $display("FAIL rst_final: got usage %0d max %0d want 0 3", usage, usage_max);
    end
  endtask

  initial begin
    out_if.ready = 1'b0;
    test_reset();
    test_single_row();
    test_fill_overflow();
    test_full_push_pop();
    test_random_ready();
    test_flush_mid_row();
    test_reset_mid_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion by 1 ms want completion");
    $fatal(1);
  end

endmodule

// File: doc/ita_output_stage.md
Name: ita_output_stage

Overview:
Parametrised output buffer and serializer for the ITA datapath, placed after activation. It replaces the fixed single-width FIFO/output-controller pair.
- Accepts one full row of N requantized lanes per push, tagged with the producing step.
- Buffers rows in a DEPTH-entry FIFO.
- Streams each row out as N/OUT_LANES beats over a valid/ready port.
- Provides early upstream stall, sticky overflow detection, and usage monitoring.

Parameters:
N, 16, lanes per input row
WI, 8, bits per lane
OUT_LANES, 16, lanes per output beat; must divide N
DEPTH, 8, FIFO rows; power of two, >= 2
STALL_TH, 2, stall_o asserts when free entries <= STALL_TH
TAG_W, 4, width of row tag (step encoding)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  synchronous clear of buffered data and status
push_i  in  1  row valid (no ready; upstream honours stall_o)
data_i  in  N*WI  row data, lane 0 in LSBs
tag_i  in  TAG_W  row tag
stall_o  out  1  upstream must stop issuing pushes
valid_o  out  1  output beat valid
ready_i  in  1  output beat accepted
data_o  out  OUT_LANES*WI  beat data; '0 when valid_o low
tag_o  out  TAG_W  tag of current row; '0 when valid_o low
last_beat_o  out  1  current beat is final beat of row
usage_o  out  $clog2(DEPTH+1)  rows stored
usage_max_o  out  $clog2(DEPTH+1)  high-water mark since reset/flush
overflow_o  out  1  sticky: push dropped while full

Behaviour:
- Clock and reset: one clock, clk_i; reset is synchronous and active-high, rst_i.
- Reset values: all outputs 0. FIFO pointers, usage, beat counter, usage_max and overflow all 0.
- BEATS = N/OUT_LANES. Beat counter bc runs 0..BEATS-1. When BEATS == 1, last_beat_o = valid_o.
- FIFO is non-fall-through. A row pushed in cycle t can appear on valid_o no earlier than t+1.
- valid_o = (usage != 0).
- data_o = head row lanes [bc*OUT_LANES +: OUT_LANES]; lowest lanes go first.
- last_beat_o = valid_o && bc == BEATS-1.
- Handshake: a beat transfers when valid_o && ready_i.
  - Non-last beat transfer: bc increments.
  - Last beat transfer: bc goes to 0 and the head row is popped.
  - Without ready_i: data_o, tag_o and bc hold stable.
- Push:
  - Accepted if usage < DEPTH, or if a pop occurs in the same cycle. Usage is unchanged on simultaneous push and pop.
  - Push while full with no pop: row dropped, overflow_o set. overflow_o stays set until rst_i or flush_i.
- Push into an empty FIFO with no pop: stored at tail; valid_o rises next cycle with bc = 0.
- stall_o is combinational: (DEPTH - usage) <= STALL_TH. STALL_TH covers upstream in-flight pipeline rows.
- usage_max_o updates every cycle to max(usage_max_o, next usage). It is registered, so it lags usage by 0 cycles at the register boundary.
- flush_i has priority over push, pop and overflow in the same cycle:
  - Pointers, usage, bc, usage_max and overflow all go to 0.
  - A concurrent push is discarded without setting overflow.
- rst_i mid-stream: identical effect to flush; any partially sent row is lost.
- Pointer wrap: DEPTH is a power of two, so pointers wrap naturally. Full/empty is decided by the usage counter, not by pointer compare.
- Storage: plain register array, no reset on data contents. Tag is stored alongside data.

Decomposition:
- ita_package additions:
  - OutLanes (default N).
  - OutFifoDepth.
  - OutStallTh.
  - typedefs: out_beat_t (logic [OutLanes-1:0][WI-1:0]), row_tag_t (step_e-compatible width), out_usage_t.
- Sub-module: ita_row_serializer. It owns bc, beat select, last_beat_o and the pop generation.
- FIFO storage and counters stay in ita_output_stage; no external fifo_v3, because of the simultaneous push/pop-when-full rule and the flush priority rule.

Test Plan:
- N=16, OUT_LANES=4, ready_i=1: push row lanes 0x00..0x0F with tag 3.
  - Required: 4 consecutive beats 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C.
  - last_beat_o only on beat 4; tag_o=3 on all beats; usage returns to 0.
- Push 8 rows with ready_i=0 (DEPTH=8, STALL_TH=2).
  - stall_o rises once usage=6.
  - Ninth push: overflow_o=1, usage stays 8.
  - Then ready_i=1: the first 8 rows drain in order, no corruption.
- Full FIFO, last beat accepted in the same cycle as a push: push accepted, usage stays 8, overflow_o stays 0, new row comes out last.
- Randomised ready_i over 100 rows: every beat appears exactly once, in order; data_o stable while valid_o && !ready_i; data_o='0 whenever valid_o=0.
- flush_i mid-row at bc=2 with a concurrent push: next cycle valid_o=0, usage=0, usage_max_o=0, overflow_o=0; the next pushed row starts at beat 0.
- rst_i asserted for 1 cycle with 5 rows buffered: all outputs 0 on the following cycle; then push 3 rows and check usage_max_o=3.
